// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// uart_rx_deserializer
// UART receive datapath. It qualifies start bits on the oversample tick,
// takes a majority vote of VOTE_SAMPLES samples around mid-bit, and runs a
// frame FSM: START, DATA (LSB first, 5..MAX_DATA_BITS bits), optional PARITY,
// then the first STOP bit. Each finished character is reported with its
// parity, framing and break status.
//
// Ports
//   pclk, presetn     clock, asynchronous active-low reset
//   baud_tick         one-pclk oversample enable (OVERSAMPLE ticks per bit)
//   rx_en             receiver enable; low aborts the current frame
//   uart_rxd          asynchronous serial line (two-flop synchronised)
//   loop, loop_txd    loopback select and transmitter output (unsynchronised)
//   data_len          data bits per character, clamped to 5..MAX_DATA_BITS
//   pen, eps, sp      parity enable, even/odd select, stick parity
//   rx_valid          one-pclk pulse per finished character
//   rx_data           character, zero-extended; held until next rx_valid
//   parity_error, frame_error, break_int   status, held with rx_data
//   rx_busy           frame in progress
//
// Optional build macro UART_RX_STICK_PARITY_EN: when defined, sp = 1 with
// pen = 1 forces the expected parity bit to ~eps. When undefined sp is
// ignored (the port stays for interface stability).
module uart_rx_deserializer #(
  parameter int MAX_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int VOTE_SAMPLES  = 3
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     baud_tick,
  input  logic                     rx_en,
  input  logic                     uart_rxd,
  input  logic                     loop,
  input  logic                     loop_txd,
  input  logic [4:0]               data_len,
  input  logic                     pen,
  input  logic                     eps,
  input  logic                     sp,
  output logic                     rx_valid,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     parity_error,
  output logic                     frame_error,
  output logic                     break_int,
  output logic                     rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (MAX_DATA_BITS > 1) ? $clog2(MAX_DATA_BITS) : 1;
  localparam int VW = $clog2(VOTE_SAMPLES + 1);
  localparam logic [TW-1:0] SAMP_LO   = TW'(OVERSAMPLE/2 - VOTE_SAMPLES/2);
  localparam logic [TW-1:0] SAMP_HI   = TW'(OVERSAMPLE/2 + VOTE_SAMPLES/2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [VW-1:0] VOTE_HALF = VW'(VOTE_SAMPLES/2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                   state_q;
  logic                     sync1_q, sync2_q;
  logic [TW-1:0]            tick_cnt_q;
  logic [VW-1:0]            ones_q;
  logic [BW-1:0]            bit_idx_q, last_idx_q;
  logic [MAX_DATA_BITS-1:0] shift_q;
  logic                     pen_q, eps_q;
  logic                     par_err_q, par_bit_q;
  logic                     armed_q;
  logic                     rx_valid_q, pe_q, fe_q, brk_q;
  logic [MAX_DATA_BITS-1:0] rx_data_q;

  logic                     serial_in, in_win, vote_pt, last_tick, vote, exp_par;
  logic [VW-1:0]            ones_d;
  logic [4:0]               len_d;
  logic [BW-1:0]            last_idx_d;

`ifdef UART_RX_STICK_PARITY_EN
  logic sp_q;
`else
  logic unused_sp;
  assign unused_sp = sp;
`endif

  assign serial_in = loop ? loop_txd : sync2_q;
  assign in_win    = (tick_cnt_q >= SAMP_LO) && (tick_cnt_q <= SAMP_HI);
  assign vote_pt   = (tick_cnt_q == SAMP_HI);
  assign last_tick = (tick_cnt_q == TICK_LAST);
  // The current sample is folded in combinationally so the decision lands on
  // the last sample tick itself.
  assign ones_d    = ones_q + VW'(serial_in);
  assign vote      = (ones_d > VOTE_HALF);

  always_comb begin
    len_d = data_len;
    if (data_len < 5'd5)                          len_d = 5'd5;
    else if (data_len > 5'(MAX_DATA_BITS))        len_d = 5'(MAX_DATA_BITS);
  end
  assign last_idx_d = BW'(len_d - 5'd1);

  // Unused high bits of shift_q stay 0, so a full-width XOR is the data parity.
  always_comb begin
    exp_par = eps_q ? (^shift_q) : ~(^shift_q);
`ifdef UART_RX_STICK_PARITY_EN
    if (sp_q) exp_par = ~eps_q;
`endif
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      ones_q     <= '0;
      bit_idx_q  <= '0;
      last_idx_q <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
`ifdef UART_RX_STICK_PARITY_EN
      sp_q       <= 1'b0;
`endif
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      armed_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync1_q    <= uart_rxd;
      sync2_q    <= sync1_q;
      rx_valid_q <= 1'b0;
      if (!rx_en) begin
        state_q    <= S_IDLE;
        tick_cnt_q <= '0;
        ones_q     <= '0;
        bit_idx_q  <= '0;
        armed_q    <= 1'b0;
      end else if (baud_tick) begin
        if (state_q != S_IDLE) begin
          tick_cnt_q <= last_tick ? '0 : tick_cnt_q + TW'(1);
          if (in_win) ones_q <= vote_pt ? '0 : ones_d;
        end
        case (state_q)
          // A start needs a fresh high-to-low transition: armed_q is set by a
          // high sample and cleared by reset, rx_en and a low stop bit, so a
          // held-low line (break) cannot retrigger.
          S_IDLE: begin
            if (serial_in) armed_q <= 1'b1;
            else if (armed_q) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
              ones_q     <= '0;
              last_idx_q <= last_idx_d;
              pen_q      <= pen;
              eps_q      <= eps;
`ifdef UART_RX_STICK_PARITY_EN
              sp_q       <= sp;
`endif
              shift_q    <= '0;
              par_err_q  <= 1'b0;
              par_bit_q  <= 1'b0;
            end
          end
          S_START: begin
            if (vote_pt && vote) begin
              state_q    <= S_IDLE;
              tick_cnt_q <= '0;
            end else if (last_tick) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end
          S_DATA: begin
            if (vote_pt) shift_q[bit_idx_q] <= vote;
            if (last_tick) begin
              if (bit_idx_q == last_idx_q) state_q <= pen_q ? S_PARITY : S_STOP;
              else                         bit_idx_q <= bit_idx_q + BW'(1);
            end
          end
          S_PARITY: begin
            if (vote_pt) begin
              par_err_q <= (vote != exp_par);
              par_bit_q <= vote;
            end
            if (last_tick) state_q <= S_STOP;
          end
          S_STOP: begin
            // Leave mid-stop so a start edge right after the stop bit is seen.
            if (vote_pt) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= shift_q;
              pe_q       <= pen_q & par_err_q;
              fe_q       <= ~vote;
              brk_q      <= (shift_q == '0) && !(pen_q && par_bit_q) && !vote;
              armed_q    <= vote;
              state_q    <= S_IDLE;
              tick_cnt_q <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign break_int    = brk_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
  localparam int MDB = 8;
  localparam int OS  = 16;
`ifdef UART_RX_STICK_PARITY_EN
  localparam bit STICK = 1'b1;
`else
  localparam bit STICK = 1'b0;
`endif

  typedef struct packed {
    logic [MDB-1:0] d;
    logic           pe;
    logic           fe;
    logic           brk;
  } rx_t;

  logic           pclk = 1'b0;
  logic           presetn, baud_tick, rx_en, uart_rxd, loop, loop_txd;
  logic [4:0]     data_len;
  logic           pen, eps, sp;
  logic           rx_valid, parity_error, frame_error, break_int, rx_busy;
  logic [MDB-1:0] rx_data;

  int  nvec = 0;
  int  nerr = 0;
  rx_t capq[$];

  uart_rx_deserializer #(.MAX_DATA_BITS(MDB), .OVERSAMPLE(OS), .VOTE_SAMPLES(3)) dut (
    .pclk(pclk), .presetn(presetn), .baud_tick(baud_tick), .rx_en(rx_en),
    .uart_rxd(uart_rxd), .loop(loop), .loop_txd(loop_txd), .data_len(data_len),
    .pen(pen), .eps(eps), .sp(sp), .rx_valid(rx_valid), .rx_data(rx_data),
    .parity_error(parity_error), .frame_error(frame_error),
    .break_int(break_int), .rx_busy(rx_busy));

  always #5 pclk = ~pclk;

  // Every high cycle of rx_valid is recorded, so a stretched pulse shows up
  // as an extra entry.
  always @(negedge pclk)
    if (rx_valid === 1'b1) capq.push_back({rx_data, parity_error, frame_error, break_int});

  // ---------------- reference model ----------------
  function automatic int eff_len(input int dl);
    return (dl < 5) ? 5 : ((dl > MDB) ? MDB : dl);
  endfunction

  function automatic rx_t model(input logic [15:0] d, input int dl, input bit pn,
                                input bit ep, input bit s, input bit pb, input bit st);
    rx_t r;
    int  ones;
    bit  want;
    r.d = '0;
    for (int i = 0; i < eff_len(dl); i++) r.d[i] = d[i];
    ones = $countones(r.d);
    // even parity: data + parity bit has an even count of ones
    want = ep ? (ones % 2 == 1) : (ones % 2 == 0);
    if (STICK && s) want = !ep;
    r.pe  = pn && (pb != want);
    r.fe  = !st;
    r.brk = (r.d == 0) && (!pn || !pb) && !st;
    return r;
  endfunction

  function automatic string fmt(input rx_t r);
    return $sformatf("d=%h pe=%b fe=%b brk=%b", r.d, r.pe, r.fe, r.brk);
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_tick(input logic v);
    if (loop) loop_txd = v; else uart_rxd = v;
    repeat (3) @(negedge pclk);
    baud_tick = 1'b1;
    @(negedge pclk);
    baud_tick = 1'b0;
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int t = 0; t < OS; t++) drive_tick((glitch && t == OS/2) ? !v : v);
  endtask

  task automatic set_cfg(input int dl, input bit pn, input bit ep, input bit s);
    data_len = 5'(dl); pen = pn; eps = ep; sp = s;
  endtask

  task automatic send_frame(input logic [15:0] d, input int nbits, input bit has_par,
                            input bit pb, input bit st, input int gl_bit, input bit scramble);
    drive_bit(1'b0, 1'b0);
    if (scramble) set_cfg($urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < nbits; i++) drive_bit(d[i], gl_bit == i);
    if (has_par) drive_bit(pb, 1'b0);
    drive_bit(st, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    presetn = 1'b0; baud_tick = 1'b0; rx_en = 1'b1; uart_rxd = 1'b1;
    loop = 1'b0; loop_txd = 1'b1; set_cfg(8, 0, 0, 0);
    repeat (3) @(negedge pclk);
    nvec++;
    if ({rx_valid, parity_error, frame_error, break_int, rx_busy} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b, want 00000",
               {rx_valid, parity_error, frame_error, break_int, rx_busy});
    end
    nvec++;
    if (rx_data !== '0) begin nerr++; $display("FAIL reset_data: got %h, want 00", rx_data); end
    presetn = 1'b1;
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic test_8n1();
    rx_t got, exp;
    set_cfg(8, 0, 0, 0); capq.delete();
    send_frame(16'h55, 8, 0, 0, 1, -1, 0);
    exp = model(16'h55, 8, 0, 0, 0, 0, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL 8n1_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL 8n1_char: got %s, want %s", fmt(got), fmt(exp)); end
    end
    nvec++;
    if (rx_data !== 8'h55) begin nerr++; $display("FAIL 8n1_hold: got %h, want 55", rx_data); end
  endtask

  task automatic test_7e1();
    rx_t got, exp;
    for (int k = 0; k < 2; k++) begin
      set_cfg(7, 1, 1, 0); capq.delete();
      send_frame(16'h41, 7, 1, 1'(k == 0), 1, -1, 0);
      exp = model(16'h41, 7, 1, 1, 0, 1'(k == 0), 1);
      nvec++;
      if (capq.size() != 1) begin nerr++; $display("FAIL 7e1_pulses[%0d]: got %0d, want 1", k, capq.size()); end
      else begin
        got = capq.pop_front();
        nvec++;
        if (got !== exp) begin nerr++; $display("FAIL 7e1_char[%0d]: got %s, want %s", k, fmt(got), fmt(exp)); end
      end
    end
  endtask

  task automatic test_false_start();
    set_cfg(8, 0, 0, 0); capq.delete();
    repeat (4) drive_tick(1'b0);
    nvec++;
    if (rx_busy !== 1'b1) begin nerr++; $display("FAIL fstart_busy: got %b, want 1", rx_busy); end
    repeat (OS) drive_tick(1'b1);
    nvec++;
    if (rx_busy !== 1'b0) begin nerr++; $display("FAIL fstart_idle: got %b, want 0", rx_busy); end
    nvec++;
    if (capq.size() != 0) begin nerr++; $display("FAIL fstart_pulses: got %0d, want 0", capq.size()); end
  endtask

  task automatic test_glitch_data();
    rx_t got, exp;
    set_cfg(8, 0, 0, 0); capq.delete();
    send_frame(16'hFF, 8, 0, 0, 1, 3, 0);
    exp = model(16'hFF, 8, 0, 0, 0, 0, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL glitch_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL glitch_char: got %s, want %s", fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_break();
    rx_t got, exp;
    set_cfg(8, 0, 0, 0); capq.delete();
    repeat (12) drive_bit(1'b0, 1'b0);
    exp = model(16'h00, 8, 0, 0, 0, 0, 0);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL break_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL break_char: got %s, want %s", fmt(got), fmt(exp)); end
    end
    repeat (2) drive_bit(1'b1, 1'b0);
    nvec++;
    if (capq.size() != 0) begin nerr++; $display("FAIL break_retrigger: got %0d, want 0", capq.size()); end
    send_frame(16'h5A, 8, 0, 0, 1, -1, 0);
    exp = model(16'h5A, 8, 0, 0, 0, 0, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL break_next_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL break_next: got %s, want %s", fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_loopback();
    rx_t got, exp;
    set_cfg(8, 0, 0, 0);
    loop_txd = 1'b1; loop = 1'b1;
    drive_bit(1'b1, 1'b0);
    uart_rxd = 1'b0;
    drive_bit(1'b1, 1'b0);
    capq.delete();
    send_frame(16'hA3, 8, 0, 0, 1, -1, 0);
    exp = model(16'hA3, 8, 0, 0, 0, 0, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL loop_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL loop_char: got %s, want %s", fmt(got), fmt(exp)); end
    end
    uart_rxd = 1'b1;
    drive_bit(1'b1, 1'b0);
    loop = 1'b0;
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic test_abort(input bit use_reset);
    rx_t            got, exp;
    logic [7:0]     d;
    d = 8'hC5;
    set_cfg(8, 0, 0, 0); capq.delete();
    if (!use_reset) begin
      send_frame(16'h96, 8, 0, 0, 1, -1, 0);
      void'(capq.pop_front());
    end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    repeat (OS/2) drive_tick(d[4]);
    nvec++;
    if (rx_busy !== 1'b1) begin nerr++; $display("FAIL abort_busy[%0d]: got %b, want 1", use_reset, rx_busy); end
    if (use_reset) begin
      presetn = 1'b0;
      #1;
      nvec++;
      if (rx_busy !== 1'b0) begin nerr++; $display("FAIL abort_rst_idle: got %b, want 0", rx_busy); end
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
    end else begin
      rx_en = 1'b0;
      @(negedge pclk);
      nvec++;
      if (rx_busy !== 1'b0) begin nerr++; $display("FAIL abort_en_idle: got %b, want 0", rx_busy); end
      repeat (OS/2) drive_tick(d[4]);
      for (int i = 5; i < 8; i++) drive_bit(d[i], 1'b0);
      drive_bit(1'b1, 1'b0);
      rx_en = 1'b1;
    end
    repeat (12) drive_bit(1'b1, 1'b0);
    nvec++;
    if (capq.size() != 0) begin nerr++; $display("FAIL abort_pulses[%0d]: got %0d, want 0", use_reset, capq.size()); end
    if (!use_reset) begin
      nvec++;
      if (rx_data !== 8'h96) begin nerr++; $display("FAIL abort_en_hold: got %h, want 96", rx_data); end
    end
    send_frame(16'h3C, 8, 0, 0, 1, -1, 0);
    exp = model(16'h3C, 8, 0, 0, 0, 0, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL abort_next_pulses[%0d]: got %0d, want 1", use_reset, capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL abort_next[%0d]: got %s, want %s", use_reset, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_stick();
    rx_t got, exp;
    set_cfg(8, 1, 0, 1); capq.delete();
    send_frame(16'h01, 8, 1, 1, 1, -1, 0);
    exp = model(16'h01, 8, 1, 0, 1, 1, 1);
    nvec++;
    if (capq.size() != 1) begin nerr++; $display("FAIL stick_pulses: got %0d, want 1", capq.size()); end
    else begin
      got = capq.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL stick_char: got %s, want %s", fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_random(input int n);
    rx_t         got, exp;
    logic [15:0] d;
    int          dl;
    bit          pn, ep, s, pb, st;
    for (int k = 0; k < n; k++) begin
      dl = ($urandom_range(0, 3) != 0) ? $urandom_range(5, MDB) : $urandom_range(0, 31);
      pn = 1'($urandom); ep = 1'($urandom); s = 1'($urandom); pb = 1'($urandom);
      st = ($urandom_range(0, 3) != 0);
      d  = 16'($urandom);
      set_cfg(dl, pn, ep, s); capq.delete();
      send_frame(d, eff_len(dl), pn, pb, st, -1, 1);
      exp = model(d, dl, pn, ep, s, pb, st);
      nvec++;
      if (capq.size() != 1) begin nerr++; $display("FAIL rand_pulses[%0d]: got %0d, want 1", k, capq.size()); end
      else begin
        got = capq.pop_front();
        nvec++;
        if (got !== exp) begin nerr++; $display("FAIL rand_char[%0d]: got %s, want %s", k, fmt(got), fmt(exp)); end
      end
      nvec++;
      if (rx_data !== exp.d) begin nerr++; $display("FAIL rand_hold[%0d]: got %h, want %h", k, rx_data, exp.d); end
      repeat ($urandom_range(0, 5)) drive_tick(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_false_start();
    test_glitch_data();
    test_break();
    test_loopback();
    test_abort(1'b1);
    test_abort(1'b0);
    test_stick();
    test_random(24);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Parametrised next-generation UART receive datapath: oversampled start-bit qualification, N-sample majority vote per bit, and a frame FSM.
- Assembles 5..MAX_DATA_BITS data bits LSB-first, then checks optional parity and the first stop bit.
- Flags parity, framing and break conditions with each received character.
- Sits between the baud generator (16x-style tick) and the RX FIFO / line-status logic.

Parameters:
- MAX_DATA_BITS, 8, widest character supported (range 5..16).
- OVERSAMPLE, 16, baud_tick pulses per bit time (even, 8..32).
- VOTE_SAMPLES, 3, samples voted around mid-bit (odd, 1..OVERSAMPLE-1).

Ports:
- pclk  in  1  system clock
- presetn  in  1  asynchronous active-low reset
- baud_tick  in  1  one-pclk oversample enable
- rx_en  in  1  receiver enable
- uart_rxd  in  1  serial line (asynchronous)
- loop  in  1  loopback select
- loop_txd  in  1  transmitter serial output for loopback
- data_len  in  5  data bits per character
- pen  in  1  parity enable
- eps  in  1  1 = even parity, 0 = odd parity
- sp  in  1  stick parity (used only with the optional feature)
- rx_valid  out  1  one-pclk pulse: character complete
- rx_data  out  MAX_DATA_BITS  received character, zero-extended
- parity_error  out  1  valid with rx_valid
- frame_error  out  1  valid with rx_valid
- break_int  out  1  valid with rx_valid
- rx_busy  out  1  FSM not IDLE

Behaviour:
- Reset: clock pclk; reset presetn is asynchronous active-low. All outputs, counters and FSM clear to 0/IDLE; the two-flop uart_rxd synchroniser resets to 1.
- Input select: serial_in = loop ? loop_txd : synchronised uart_rxd. loop_txd is not synchronised.
- Sampling: all activity advances only on baud_tick; tick_cnt runs 0..OVERSAMPLE-1 per bit.
  - Samples are taken at tick_cnt = OVERSAMPLE/2 - VOTE_SAMPLES/2 .. OVERSAMPLE/2 + VOTE_SAMPLES/2.
  - Voted bit = 1 iff ones > VOTE_SAMPLES/2. The decision is made on the last sample tick.
- IDLE: on a baud_tick with serial_in = 0, go to START with tick_cnt = 0.
  - data_len, pen, eps and sp are latched on this transition; changes mid-frame are ignored.
  - data_len < 5 is treated as 5; data_len > MAX_DATA_BITS is treated as MAX_DATA_BITS.
- START: if the voted bit is 1 (false start), return to IDLE with no flags. Otherwise move to DATA at tick_cnt = OVERSAMPLE-1 with bit_idx = 0.
- DATA: store each voted bit at rx_shift[bit_idx]. After the last bit's final tick, go to PARITY if pen, else STOP.
- PARITY: expected parity = eps ? ^data : ~^data. par_err = (voted != expected).
- STOP: decision on the first stop bit only.
  - fe = (voted == 0).
  - brk = data all 0, parity bit 0 (if pen), and stop bit 0.
  - Return to IDLE immediately after the decision tick so the next start edge is detectable mid-stop.
- Output timing: rx_valid pulses exactly one pclk, on the cycle after the STOP decision tick. In that same cycle, rx_data, parity_error, frame_error and break_int update and then hold until the next rx_valid.
  - rx_data bits at positions >= effective data_len are 0.
- rx_busy = 1 in START, DATA, PARITY and STOP.
- rx_en = 0 (synchronous): FSM to IDLE, counters cleared, partial character discarded, no rx_valid. Held outputs are retained. rx_en = 0 wins over a simultaneous baud_tick.
- Reset asserted mid-frame: immediate abort, no rx_valid. After release, wait for a fresh high-to-low transition.
- baud_tick absent: state frozen indefinitely.

Optional Feature:
- Macro: UART_RX_STICK_PARITY_EN.
- Defined: when the latched sp = 1 and pen = 1, expected parity = ~eps (eps = 1 means parity bit 0; eps = 0 means parity bit 1).
- Undefined: sp is ignored and parity follows eps only. The port remains present so the interface is stable.

Test Plan:
- 8N1, data_len = 8, pen = 0, byte 0x55 on uart_rxd at 16 ticks/bit -> one rx_valid pulse, rx_data = 0x55, parity_error = frame_error = break_int = 0.
- 7E1, data_len = 7, pen = 1, eps = 1, char 0x41 sent with parity bit 1 (wrong) -> rx_data = 0x41, parity_error = 1; resend with parity bit 0 -> parity_error = 0.
- Start glitch: line low for 4 ticks then high -> no rx_valid, rx_busy returns to 0 within 1 bit time. Also: a 1-tick low spike at mid-bit inside data bit 3 of 0xFF -> rx_data = 0xFF.
- Break: line held low 12 bit times, 8N1 -> rx_valid, rx_data = 0x00, frame_error = 1, break_int = 1; no further rx_valid until the line returns high and a new start bit arrives.
- Loopback: loop = 1, uart_rxd stuck 0, 0xA3 driven on loop_txd -> rx_data = 0xA3, no break.
- Abort cases: presetn asserted during data bit 4, or rx_en dropped during data bit 4 -> rx_valid never pulses; a following 0x3C frame is received correctly. With the macro defined, sp = 1 and eps = 0 with parity bit 1 -> parity_error = 0.
